// File: rtl/soml_pkg.sv
// Shared SOML decoder constants, FSM state encoding and sideband record type.
package soml_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    localparam int unsigned SOML_N_COLS = 2;
    localparam int unsigned SOML_N_ROWS = 2;
    localparam int unsigned SOML_RD_LAT = 2;
    localparam int unsigned SOML_ADDR_W = 2;

    typedef enum logic [1:0] {
        StIdle  = ST_IDLE,
        StRun   = ST_RUN,
        StDrain = ST_DRAIN,
        StDone  = ST_DONE
    } soml_state_e;

    typedef struct packed {
        logic valid;
        logic first;
        logic last;
    } soml_side_t;

endpackage

// File: rtl/soml_addr_sequencer_if.sv
// Control/address bundle between decoder control, the sequencer and the H/S memories.
interface soml_addr_sequencer_if #(
    parameter int unsigned ADDR_W = soml_pkg::SOML_ADDR_W
);

    logic              start;
    logic              hold;
    logic              abort;
    logic [ADDR_W-1:0] addr_colS;
    logic [ADDR_W-1:0] addr_rowH;
    logic              rd_en;
    logic              out_valid;
    logic              acc_first;
    logic              acc_last;
    logic              busy;
    logic              done;

    modport master (
        output start, hold, abort,
        input  addr_colS, addr_rowH, rd_en, out_valid, acc_first, acc_last, busy, done
    );

    modport slave (
        input  start, hold, abort,
        output addr_colS, addr_rowH, rd_en, out_valid, acc_first, acc_last, busy, done
    );

endinterface

// File: rtl/soml_addr_counter.sv
// colS/rowH wrap counter pair; clr has priority over inc.
module soml_addr_counter
    import soml_pkg::*;
#(
    parameter int unsigned N_COLS = SOML_N_COLS,
    parameter int unsigned N_ROWS = SOML_N_ROWS,
    parameter int unsigned ADDR_W = SOML_ADDR_W
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              inc_i,
    input  logic              clr_i,
    output logic [ADDR_W-1:0] col_o,
    output logic [ADDR_W-1:0] row_o,
    output logic              last_o
);

    localparam logic [ADDR_W-1:0] ColMax = ADDR_W'(N_COLS - 1);
    localparam logic [ADDR_W-1:0] RowMax = ADDR_W'(N_ROWS - 1);

    logic [ADDR_W-1:0] col_q, col_d;
    logic [ADDR_W-1:0] row_q, row_d;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            col_q <= '0;
            row_q <= '0;
        end else begin
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    always_comb begin
        col_d = col_q;
        row_d = row_q;
        if (clr_i) begin
            col_d = '0;
            row_d = '0;
        end else if (inc_i) begin
            if (col_q == ColMax) begin
                col_d = '0;
                row_d = row_q + ADDR_W'(1);
            end else begin
                col_d = col_q + ADDR_W'(1);
            end
        end
    end

    assign col_o  = col_q;
    assign row_o  = row_q;
    assign last_o = (col_q == ColMax) && (row_q == RowMax);

endmodule

// File: rtl/soml_addr_sequencer.sv
// Frame controller for the SOML H/S memory walk: address scan, read strobe and
// accumulator sideband aligned to the memory read latency.
module soml_addr_sequencer
    import soml_pkg::*;
#(
    parameter int unsigned N_COLS = SOML_N_COLS,
    parameter int unsigned N_ROWS = SOML_N_ROWS,
    parameter int unsigned ADDR_W = SOML_ADDR_W,
    parameter int unsigned RD_LAT = SOML_RD_LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    soml_addr_sequencer_if.slave  bus
);

    localparam int unsigned       DrainW    = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [DrainW-1:0] DrainLast = DrainW'(RD_LAT - 1);
    localparam logic [ADDR_W-1:0] ColMax    = ADDR_W'(N_COLS - 1);

    soml_state_e             state_q, state_d;
    logic       [DrainW-1:0] drain_cnt_q, drain_cnt_d;
    soml_side_t [RD_LAT-1:0] side_q, side_d;

    logic [ADDR_W-1:0] col, row;
    logic              scan_last;
    logic              issue;
    logic              cnt_clr;

    assign issue   = (state_q == StRun) && !bus.hold && !bus.abort;
    // Counter rests at zero everywhere except RUN, so IDLE/DRAIN addresses read 0.
    assign cnt_clr = bus.abort || (issue && scan_last) || (state_q != StRun);

    soml_addr_counter #(
        .N_COLS (N_COLS),
        .N_ROWS (N_ROWS),
        .ADDR_W (ADDR_W)
    ) u_addr_counter (
        .clk_i  (clk),
        .rst_ni (rst),
        .inc_i  (issue),
        .clr_i  (cnt_clr),
        .col_o  (col),
        .row_o  (row),
        .last_o (scan_last)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            drain_cnt_q <= '0;
            side_q      <= '0;
        end else begin
            state_q     <= state_d;
            drain_cnt_q <= drain_cnt_d;
            side_q      <= side_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.abort) begin
            state_d = StIdle;
        end else begin
            case (state_q)
                StIdle:  if (bus.start) state_d = StRun;
                StRun:   if (issue && scan_last) state_d = StDrain;
                StDrain: if (drain_cnt_q == DrainLast) state_d = StDone;
                StDone:  state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    always_comb begin
        drain_cnt_d = (state_q == StDrain) ? drain_cnt_q + DrainW'(1) : '0;
    end

    // Sideband qualified by issue at capture, so first/last are 0 on bubbles.
    always_comb begin
        side_d       = side_q;
        side_d[0]    = '{valid: issue,
                         first: issue && (col == '0),
                         last:  issue && (col == ColMax)};
        for (int unsigned i = 1; i < RD_LAT; i++) begin
            side_d[i] = side_q[i-1];
        end
        if (bus.abort) begin
            side_d = '0;
        end
    end

    always_comb begin
        bus.addr_colS = col;
        bus.addr_rowH = row;
        bus.rd_en     = issue;
        bus.out_valid = side_q[RD_LAT-1].valid;
        bus.acc_first = side_q[RD_LAT-1].first;
        bus.acc_last  = side_q[RD_LAT-1].last;
        bus.busy      = (state_q != StIdle);
        bus.done      = (state_q == StDone) && !bus.abort;
    end

endmodule

// File: tb/tb_soml_addr_sequencer.sv
// Self-checking bench: directed vector tables, hand sequences and randomized traffic
// checked against a frame-level reference model.
module tb_soml_addr_sequencer;

    typedef struct packed {
        logic       rd_en;
        logic [1:0] row;
        logic [1:0] col;
        logic       valid;
        logic       first;
        logic       last;
        logic       busy;
        logic       done;
    } outs_t;

    typedef struct {
        int    s;
        int    h;
        int    a;
        outs_t exp;
    } vec_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    soml_addr_sequencer_if #(.ADDR_W(2)) bus_a ();
    soml_addr_sequencer_if #(.ADDR_W(2)) bus_b ();

    soml_addr_sequencer #(
        .N_COLS (2),
        .N_ROWS (2),
        .ADDR_W (2),
        .RD_LAT (2)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    soml_addr_sequencer #(
        .N_COLS (1),
        .N_ROWS (3),
        .ADDR_W (2),
        .RD_LAT (1)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int sel     = 0;

    // Reference model: beat index k walks 0..NC*NR-1, address = (k/NC, k%NC).
    int         m_nc, m_nr, m_rl;
    int         m_phase;  // 0 idle, 1 scanning, 2 draining, 3 done
    int         m_k;
    int         m_drain;
    logic [2:0] m_dq[$];

    function automatic outs_t mk(int rd, int row, int col, int v, int f, int l, int b, int d);
        outs_t o;
        o.rd_en = rd[0];
        o.row   = row[1:0];
        o.col   = col[1:0];
        o.valid = v[0];
        o.first = f[0];
        o.last  = l[0];
        o.busy  = b[0];
        o.done  = d[0];
        return o;
    endfunction

    function automatic vec_t mv(int s, int h, int a, outs_t e);
        vec_t v;
        v.s = s;
        v.h = h;
        v.a = a;
        v.exp = e;
        return v;
    endfunction

    task automatic model_reset(int nc, int nr, int rl);
        m_nc = nc;
        m_nr = nr;
        m_rl = rl;
        m_phase = 0;
        m_k = 0;
        m_drain = 0;
        m_dq.delete();
        for (int i = 0; i < rl; i++) m_dq.push_back(3'b000);
    endtask

    function automatic outs_t model_out(int s, int h, int a);
        outs_t o;
        int    r;
        int    c;
        logic [2:0] sb;
        r  = (m_phase == 1) ? m_k / m_nc : 0;
        c  = (m_phase == 1) ? m_k % m_nc : 0;
        sb = m_dq[0];
        o.rd_en = (m_phase == 1) && (h == 0) && (a == 0);
        o.row   = r[1:0];
        o.col   = c[1:0];
        o.valid = sb[2];
        o.first = sb[1];
        o.last  = sb[0];
        o.busy  = (m_phase != 0);
        o.done  = (m_phase == 3) && (a == 0) && (s >= 0);
        return o;
    endfunction

    task automatic model_adv(int s, int h, int a);
        logic rd;
        int   c;
        rd = (m_phase == 1) && (h == 0) && (a == 0);
        c  = m_k % m_nc;
        void'(m_dq.pop_front());
        m_dq.push_back({rd, rd && (c == 0), rd && (c == m_nc - 1)});
        if (a != 0) begin
            m_phase = 0;
            m_k = 0;
            for (int i = 0; i < m_rl; i++) m_dq[i] = 3'b000;
        end else begin
            case (m_phase)
                0: if (s != 0) begin
                    m_phase = 1;
                    m_k = 0;
                end
                1: if (rd) begin
                    m_k++;
                    if (m_k == m_nc * m_nr) begin
                        m_phase = 2;
                        m_k = 0;
                        m_drain = m_rl;
                    end
                end
                2: begin
                    m_drain--;
                    if (m_drain == 0) m_phase = 3;
                end
                default: m_phase = 0;
            endcase
        end
    endtask

    function automatic outs_t sample();
        outs_t o;
        if (sel == 0) begin
            o = '{bus_a.rd_en, bus_a.addr_rowH, bus_a.addr_colS, bus_a.out_valid,
                  bus_a.acc_first, bus_a.acc_last, bus_a.busy, bus_a.done};
        end else begin
            o = '{bus_b.rd_en, bus_b.addr_rowH, bus_b.addr_colS, bus_b.out_valid,
                  bus_b.acc_first, bus_b.acc_last, bus_b.busy, bus_b.done};
        end
        return o;
    endfunction

    task automatic check(string name, outs_t act, outs_t exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got rd=%b row=%0d col=%0d v=%b f=%b l=%b busy=%b done=%b, want rd=%b row=%0d col=%0d v=%b f=%b l=%b busy=%b done=%b",
                     name, act.rd_en, act.row, act.col, act.valid, act.first, act.last,
                     act.busy, act.done, exp.rd_en, exp.row, exp.col, exp.valid, exp.first,
                     exp.last, exp.busy, exp.done);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic drive(int s, int h, int a);
        bus_a.start = s[0];
        bus_a.hold  = h[0];
        bus_a.abort = a[0];
        bus_b.start = s[0];
        bus_b.hold  = h[0];
        bus_b.abort = a[0];
    endtask

    // One clock cycle: apply inputs after the falling edge, compare before the rising edge.
    task automatic cycle(string tag, int s, int h, int a, output outs_t act);
        @(negedge clk);
        drive(s, h, a);
        #1;
        act = sample();
        check(tag, act, model_out(s, h, a));
        model_adv(s, h, a);
    endtask

    task automatic do_reset(int nc, int nr, int rl);
        @(negedge clk);
        drive(0, 0, 0);
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        model_reset(nc, nr, rl);
    endtask

    vec_t  t1[9];
    vec_t  t2[10];
    outs_t act;
    outs_t zero;

    initial begin
        zero = mk(0, 0, 0, 0, 0, 0, 0, 0);

        t1[0] = mv(1, 0, 0, zero);
        t1[1] = mv(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0));
        t1[2] = mv(0, 0, 0, mk(1, 0, 1, 0, 0, 0, 1, 0));
        t1[3] = mv(0, 0, 0, mk(1, 1, 0, 1, 1, 0, 1, 0));
        t1[4] = mv(0, 0, 0, mk(1, 1, 1, 1, 0, 1, 1, 0));
        t1[5] = mv(0, 0, 0, mk(0, 0, 0, 1, 1, 0, 1, 0));
        t1[6] = mv(0, 0, 0, mk(0, 0, 0, 1, 0, 1, 1, 0));
        t1[7] = mv(0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        t1[8] = mv(0, 0, 0, zero);

        t2[0] = mv(1, 0, 0, zero);
        t2[1] = mv(0, 0, 0, mk(1, 0, 0, 0, 0, 0, 1, 0));
        t2[2] = mv(0, 1, 0, mk(0, 0, 1, 0, 0, 0, 1, 0));
        t2[3] = mv(0, 0, 0, mk(1, 0, 1, 1, 1, 0, 1, 0));
        t2[4] = mv(0, 0, 0, mk(1, 1, 0, 0, 0, 0, 1, 0));
        t2[5] = mv(0, 0, 0, mk(1, 1, 1, 1, 0, 1, 1, 0));
        t2[6] = mv(0, 0, 0, mk(0, 0, 0, 1, 1, 0, 1, 0));
        t2[7] = mv(0, 0, 0, mk(0, 0, 0, 1, 0, 1, 1, 0));
        t2[8] = mv(0, 0, 0, mk(0, 0, 0, 0, 0, 0, 1, 1));
        t2[9] = mv(0, 0, 0, zero);

        drive(0, 0, 0);
        sel = 0;
        #1;
        check("reset_state", sample(), zero);
        do_reset(2, 2, 2);

        for (int i = 0; i < 9; i++) begin
            cycle($sformatf("t1_model_c%0d", i), t1[i].s, t1[i].h, t1[i].a, act);
            check($sformatf("t1_table_c%0d", i), act, t1[i].exp);
        end
        for (int i = 0; i < 10; i++) begin
            cycle($sformatf("t2_model_c%0d", i), t2[i].s, t2[i].h, t2[i].a, act);
            check($sformatf("t2_table_c%0d", i), act, t2[i].exp);
        end

        // Abort mid-RUN on cycle 3.
        cycle("t3_c0", 1, 0, 0, act);
        cycle("t3_c1", 0, 0, 0, act);
        cycle("t3_c2", 0, 0, 0, act);
        cycle("t3_c3", 0, 0, 1, act);
        for (int i = 4; i < 10; i++) begin
            cycle($sformatf("t3_model_c%0d", i), 0, 0, 0, act);
            check($sformatf("t3_idle_c%0d", i), act, zero);
        end

        // start held high through a frame: one frame only; then start+abort in IDLE.
        begin
            int beats;
            int dones;
            beats = 0;
            dones = 0;
            for (int i = 0; i < 8; i++) begin
                cycle($sformatf("t4_c%0d", i), 1, 0, 0, act);
                beats += int'(act.rd_en);
                dones += int'(act.done);
            end
            cycle("t4_c8", 0, 0, 0, act);
            check("t4_idle_after_frame", act, zero);
            check_int("t4_beats", beats, 4);
            check_int("t4_dones", dones, 1);
            cycle("t4_start_abort", 1, 0, 1, act);
            cycle("t4_after_pair", 0, 0, 0, act);
            check("t4_no_run", act, zero);
        end

        // Asynchronous reset mid-RUN.
        cycle("t5_c0", 1, 0, 0, act);
        cycle("t5_c1", 0, 0, 0, act);
        @(negedge clk);
        drive(0, 0, 0);
        #1;
        rst = 1'b0;
        #1;
        check("t5_async_zero", sample(), zero);
        @(posedge clk);
        #1;
        check("t5_held_zero", sample(), zero);
        @(negedge clk);
        rst = 1'b1;
        model_reset(2, 2, 2);
        cycle("t5_restart", 1, 0, 0, act);
        cycle("t5_first", 0, 0, 0, act);
        check("t5_first_addr", act, mk(1, 0, 0, 0, 0, 0, 1, 0));
        for (int i = 0; i < 10; i++) cycle($sformatf("t5_tail_c%0d", i), 0, 0, 0, act);

        // Random traffic against the model, default configuration.
        for (int i = 0; i < 400; i++) begin
            int s, h, a;
            s = ($urandom_range(3) == 0) ? 1 : 0;
            h = ($urandom_range(2) == 0) ? 1 : 0;
            a = ($urandom_range(29) == 0) ? 1 : 0;
            cycle($sformatf("rand_a_%0d", i), s, h, a, act);
        end

        // Parameter sweep: N_COLS=1, N_ROWS=3, RD_LAT=1.
        do_reset(1, 3, 1);
        sel = 1;
        begin
            int done_at;
            int fl_beats;
            done_at = -1;
            fl_beats = 0;
            cycle("t6_c0", 1, 0, 0, act);
            for (int i = 1; i < 8; i++) begin
                cycle($sformatf("t6_c%0d", i), 0, 0, 0, act);
                if (act.done && done_at < 0) done_at = i;
                if (act.valid && act.first && act.last) fl_beats++;
            end
            check_int("t6_done_cycle", done_at, 5);
            check_int("t6_first_last_beats", fl_beats, 3);
        end
        for (int i = 0; i < 200; i++) begin
            int s, h, a;
            s = ($urandom_range(2) == 0) ? 1 : 0;
            h = ($urandom_range(3) == 0) ? 1 : 0;
            a = ($urandom_range(24) == 0) ? 1 : 0;
            cycle($sformatf("rand_b_%0d", i), s, h, a, act);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
